// File: rtl/argmax_pipe.sv
// Pipelined arg-max over N_INPUTS scores: one vector per cycle in, the winning index,
// the winning value and the best-minus-second margin out, LEVELS+1 cycles after sampling.
module argmax_pipe #(
    parameter int WIDTH         = 40,
    parameter int N_INPUTS      = 10,
    parameter bit SIGNED        = 1'b1,
    parameter bit REVERSE_INDEX = 1'b1,
    localparam int IDX_W        = $clog2(N_INPUTS),
    localparam int LEVELS       = $clog2(N_INPUTS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [N_INPUTS*WIDTH-1:0] input_nums,
    output logic [IDX_W-1:0]          predicted_digit,
    output logic [WIDTH-1:0]          max_value,
    output logic [WIDTH:0]            margin,
    output logic                      done
);

    typedef struct packed {
        logic [WIDTH-1:0] v1;
        logic [IDX_W-1:0] i1;
        logic [WIDTH-1:0] v2;
        logic [IDX_W-1:0] i2;
        logic             v2_ok;
    } node_t;

    function automatic int level_cnt(input int l);
        return (N_INPUTS + (1 << l) - 1) >> l;
    endfunction

    function automatic int level_off(input int l);
        int s;
        s = 0;
        for (int m = 0; m < l; m++) begin
            s += level_cnt(m);
        end
        return s;
    endfunction

    localparam int TOTAL    = level_off(LEVELS + 1);
    localparam int ROOT_OFF = level_off(LEVELS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_INPUTS - 1);

    function automatic logic gt(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic r;
        if (SIGNED) begin
            r = ($signed(a) > $signed(b));
        end else begin
            r = (a > b);
        end
        return r;
    endfunction

    function automatic logic [WIDTH:0] ext(input logic [WIDTH-1:0] a);
        logic [WIDTH:0] r;
        if (SIGNED) begin
            r = {a[WIDTH-1], a};
        end else begin
            r = {1'b0, a};
        end
        return r;
    endfunction

    function automatic node_t leaf(input logic [WIDTH-1:0] v, input logic [IDX_W-1:0] i);
        node_t n;
        n.v1    = v;
        n.i1    = i;
        n.v2    = '0;
        n.i2    = '0;
        n.v2_ok = 1'b0;
        return n;
    endfunction

    // a always holds lower raw indices than b, so b only wins a strict comparison.
    function automatic node_t merge(input node_t a, input node_t b);
        node_t m;
        m.v2_ok = 1'b1;
        if (gt(b.v1, a.v1)) begin
            m.v1 = b.v1;
            m.i1 = b.i1;
            if (b.v2_ok && gt(b.v2, a.v1)) begin
                m.v2 = b.v2;
                m.i2 = b.i2;
            end else begin
                m.v2 = a.v1;
                m.i2 = a.i1;
            end
        end else begin
            m.v1 = a.v1;
            m.i1 = a.i1;
            if (!a.v2_ok || gt(b.v1, a.v2)) begin
                m.v2 = b.v1;
                m.i2 = b.i1;
            end else begin
                m.v2 = a.v2;
                m.i2 = a.i2;
            end
        end
        return m;
    endfunction

    node_t             tree_r [TOTAL];
    logic [LEVELS:0]   valid_r;
    node_t             root_s;

    assign root_s = tree_r[ROOT_OFF];

    // Valid bits travel alongside the data; an idle cycle becomes a bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_r <= '0;
        end else begin
            valid_r <= {valid_r[LEVELS-1:0], start};
        end
    end

    for (genvar k = 0; k < N_INPUTS; k++) begin : g_leaf
        // Stage 0: capture raw score k with its index.
        always_ff @(posedge clk) begin
            if (reset) begin
                tree_r[k] <= '0;
            end else if (start) begin
                tree_r[k] <= leaf(input_nums[k*WIDTH +: WIDTH], IDX_W'(k));
            end
        end
    end

    for (genvar l = 1; l <= LEVELS; l++) begin : g_lvl
        localparam int PREV_CNT = level_cnt(l - 1);
        localparam int PREV_OFF = level_off(l - 1);
        localparam int CUR_OFF  = level_off(l);
        for (genvar j = 0; j < level_cnt(l); j++) begin : g_node
            if (2 * j + 1 < PREV_CNT) begin : g_merge
                // One comparator-plus-mux depth per level.
                always_ff @(posedge clk) begin
                    if (reset) begin
                        tree_r[CUR_OFF+j] <= '0;
                    end else begin
                        tree_r[CUR_OFF+j] <= merge(tree_r[PREV_OFF+2*j], tree_r[PREV_OFF+2*j+1]);
                    end
                end
            end else begin : g_pass
                // Odd node out is carried unchanged to keep stage alignment.
                always_ff @(posedge clk) begin
                    if (reset) begin
                        tree_r[CUR_OFF+j] <= '0;
                    end else begin
                        tree_r[CUR_OFF+j] <= tree_r[PREV_OFF+2*j];
                    end
                end
            end
        end
    end

    // Result registers load only on a valid root and hold between pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            done            <= 1'b0;
            predicted_digit <= '0;
            max_value       <= '0;
            margin          <= '0;
        end else begin
            done <= valid_r[LEVELS];
            if (valid_r[LEVELS]) begin
                predicted_digit <= REVERSE_INDEX ? (LAST_IDX - root_s.i1) : root_s.i1;
                max_value       <= root_s.v1;
                margin          <= root_s.v2_ok ? (ext(root_s.v1) - ext(root_s.v2)) : '0;
            end
        end
    end

endmodule

// File: tb/tb_argmax_pipe.sv
// Scoreboard bench for argmax_pipe: a signed/reversed N=10 instance and an unsigned N=7 instance.
module tb_argmax_pipe;

    localparam int N10 = 10;
    localparam int W10 = 40;
    localparam int N7  = 7;
    localparam int W7  = 16;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 start10, start7;
    logic [N10*W10-1:0]   in10;
    logic [N7*W7-1:0]     in7;
    logic [3:0]           digit10;
    logic [39:0]          max10;
    logic [40:0]          margin10;
    logic                 done10;
    logic [2:0]           digit7;
    logic [15:0]          max7;
    logic [16:0]          margin7;
    logic                 done7;

    int cyc      = 0;
    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int          cyc;
        logic [3:0]  digit;
        logic [39:0] maxv;
        logic [40:0] margin;
    } exp_t;

    exp_t q10[$];
    exp_t q7[$];

    argmax_pipe #(.WIDTH(W10), .N_INPUTS(N10), .SIGNED(1'b1), .REVERSE_INDEX(1'b1)) dut10 (
        .clk(clk), .reset(reset), .start(start10), .input_nums(in10),
        .predicted_digit(digit10), .max_value(max10), .margin(margin10), .done(done10)
    );

    argmax_pipe #(.WIDTH(W7), .N_INPUTS(N7), .SIGNED(1'b0), .REVERSE_INDEX(1'b0)) dut7 (
        .clk(clk), .reset(reset), .start(start7), .input_nums(in7),
        .predicted_digit(digit7), .max_value(max7), .margin(margin7), .done(done7)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: first maximum wins ties; runner-up is the largest of the rest.
    function automatic exp_t model(input logic [399:0] v, input int n, input int w,
                                   input bit sgn, input bit rev);
        longint s [10];
        longint mask, second;
        int     best;
        exp_t   e;
        mask = (longint'(1) << w) - 1;
        for (int k = 0; k < n; k++) begin
            s[k] = longint'(64'(v >> (k * w))) & mask;
            if (sgn && (((s[k] >> (w - 1)) & 1) == 1)) s[k] = s[k] - (longint'(1) << w);
        end
        best = 0;
        for (int k = 1; k < n; k++) if (s[k] > s[best]) best = k;
        second = (best == 0) ? s[1] : s[0];
        for (int k = 0; k < n; k++) if (k != best && s[k] > second) second = s[k];
        e.cyc    = 0;
        e.digit  = rev ? 4'(n - 1 - best) : 4'(best);
        e.maxv   = 40'(s[best] & mask);
        e.margin = 41'(s[best] - second);
        return e;
    endfunction

    function automatic logic [399:0] poke(input logic [399:0] v, input int k, input int w,
                                          input logic [63:0] val);
        logic [399:0] m;
        m = 400'((64'd1 << w) - 64'd1) << (k * w);
        return (v & ~m) | ((400'(val) << (k * w)) & m);
    endfunction

    function automatic logic [399:0] fill(input int n, input int w, input logic [63:0] val);
        logic [399:0] v;
        v = '0;
        for (int k = 0; k < n; k++) v = poke(v, k, w, val);
        return v;
    endfunction

    function automatic logic [399:0] rand_vec(input int n, input int w);
        logic [399:0] v;
        logic [63:0]  r;
        int           mode;
        v    = '0;
        mode = $urandom_range(0, 3);
        for (int k = 0; k < n; k++) begin
            r = {$urandom, $urandom};
            if (mode == 0) r = 64'($urandom_range(0, 3)) - 64'd2;
            v = poke(v, k, w, r);
        end
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        start10 = 1'b0;
        start7  = 1'b0;
    endtask

    task automatic set10(input logic [399:0] v, input logic [3:0] d, input logic [39:0] m,
                         input logic [40:0] mg);
        exp_t e;
        start10 = 1'b1;
        in10    = v[N10*W10-1:0];
        e.cyc = cyc + 6; e.digit = d; e.maxv = m; e.margin = mg;
        q10.push_back(e);
    endtask

    task automatic set7(input logic [399:0] v, input logic [3:0] d, input logic [39:0] m,
                        input logic [40:0] mg);
        exp_t e;
        start7 = 1'b1;
        in7    = v[N7*W7-1:0];
        e.cyc = cyc + 5; e.digit = d; e.maxv = m; e.margin = mg;
        q7.push_back(e);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_done10"},   64'(done10),   64'd0);
        check({tag, "_digit10"},  64'(digit10),  64'd0);
        check({tag, "_max10"},    64'(max10),    64'd0);
        check({tag, "_margin10"}, 64'(margin10), 64'd0);
        check({tag, "_done7"},    64'(done7),    64'd0);
        check({tag, "_digit7"},   64'(digit7),   64'd0);
        check({tag, "_max7"},     64'(max7),     64'd0);
        check({tag, "_margin7"},  64'(margin7),  64'd0);
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin : mon
        exp_t e;
        if (done10 === 1'b1) begin
            if (q10.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL done10_unexpected: got done=1 expected no pulse (cycle %0d)", cyc);
            end else begin
                e = q10.pop_front();
                check("latency10", 64'(cyc), 64'(e.cyc));
                check("digit10", 64'(digit10), 64'(e.digit));
                check("max10", 64'(max10), 64'(e.maxv));
                check("margin10", 64'(margin10), 64'(e.margin));
            end
        end else if (q10.size() != 0 && q10[0].cyc <= cyc) begin
            n_checks++; n_fail++;
            $display("FAIL done10_missing: got done=0 expected pulse (cycle %0d)", cyc);
            void'(q10.pop_front());
        end
        if (done7 === 1'b1) begin
            if (q7.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL done7_unexpected: got done=1 expected no pulse (cycle %0d)", cyc);
            end else begin
                e = q7.pop_front();
                check("latency7", 64'(cyc), 64'(e.cyc));
                check("digit7", 64'(digit7), 64'(e.digit));
                check("max7", 64'(max7), 64'(e.maxv[15:0]));
                check("margin7", 64'(margin7), 64'(e.margin[16:0]));
            end
        end else if (q7.size() != 0 && q7[0].cyc <= cyc) begin
            n_checks++; n_fail++;
            $display("FAIL done7_missing: got done=0 expected pulse (cycle %0d)", cyc);
            void'(q7.pop_front());
        end
    end

    initial begin
        logic [399:0] v;
        exp_t         e;

        reset = 1'b1; start10 = 1'b0; start7 = 1'b0; in10 = '0; in7 = '0;
        repeat (3) @(posedge clk);
        #1;
        // A start coinciding with reset must be ignored.
        v = '0;
        for (int k = 0; k < N10; k++) v = poke(v, k, W10, 64'(k * 10));
        start10 = 1'b1; in10 = v[N10*W10-1:0];
        start7  = 1'b1; in7  = v[N7*W7-1:0];
        tick();
        reset = 1'b0;
        @(negedge clk);
        check_zero_outputs("reset");

        // Directed vectors from the test plan.
        tick();
        set10(v, 4'd0, 40'd90, 41'd10);
        v = '0;
        for (int k = 0; k < N7; k++) v = poke(v, k, W7, 64'(k * 10));
        v = poke(v, 1, W7, 64'd499);
        v = poke(v, 6, W7, 64'd500);
        set7(v, 4'd6, 40'd500, 41'd1);
        tick();
        set10(fill(N10, W10, 64'd7), 4'd9, 40'd7, 41'd0);
        v = poke(fill(N7, W7, 64'd100), 0, W7, 64'd60000);
        set7(v, 4'd0, 40'd60000, 41'd59900);
        tick();
        v = fill(N10, W10, -64'sd100);
        v = poke(v, 3, W10, -64'sd1);
        v = poke(v, 5, W10, -64'sd2);
        set10(v, 4'd6, 40'hFF_FFFF_FFFF, 41'd1);
        tick();
        v = poke(fill(N10, W10, 64'hFFFF_FF80_0000_0000), 0, W10, 64'h7F_FFFF_FFFF);
        set10(v, 4'd9, 40'h7F_FFFF_FFFF, 41'h0FF_FFFF_FFFF);
        tick();
        set10(poke(poke('0, 2, W10, 64'd1002), 3, W10, 64'd500), 4'd7, 40'd1002, 41'd502);
        tick();
        set10(poke(poke('0, 7, W10, 64'd1007), 8, W10, 64'd500), 4'd2, 40'd1007, 41'd507);
        tick();
        set10(poke(poke('0, 4, W10, 64'd1004), 5, W10, 64'd500), 4'd5, 40'd1004, 41'd504);
        repeat (10) tick();

        // Reset two cycles after a start: the vector must vanish and outputs clear.
        tick();
        start10 = 1'b1; in10 = fill(N10, W10, 64'd3);
        start7  = 1'b1; in7  = in10[N7*W7-1:0];
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (10) tick();
        @(negedge clk);
        check_zero_outputs("midreset");

        // Randomised traffic with random gaps and back-to-back runs.
        for (int i = 0; i < 300; i++) begin
            tick();
            if ($urandom_range(0, 3) != 0) begin
                v = rand_vec(N10, W10);
                e = model(v, N10, W10, 1'b1, 1'b1);
                set10(v, e.digit, e.maxv, e.margin);
            end
            if ($urandom_range(0, 3) != 0) begin
                v = rand_vec(N7, W7);
                e = model(v, N7, W7, 1'b0, 1'b0);
                set7(v, e.digit, e.maxv, e.margin);
            end
        end
        repeat (12) tick();
        @(negedge clk);
        check("drained10", 64'(q10.size()), 64'd0);
        check("drained7", 64'(q7.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
